// File: rtl/avalon_slave_mem_pkg.sv
// avalon_slave_mem_pkg: shared limits, host FSM states and error causes
package avalon_slave_mem_pkg;
  localparam int MAX_WAIT = 15;
  typedef enum logic {HOST_IDLE, HOST_ACK} host_state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_RW_BOTH, ERR_MISALIGN} err_t;
endpackage

// File: rtl/avalon_slave_ram.sv
// avalon_slave_ram: byte-enabled RAM, one write port, two registered read ports
module avalon_slave_ram
  import avalon_slave_mem_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [DW/8-1:0] wbe,
  input  logic          re_a,
  input  logic [AW-1:0] addr_a,
  output logic [DW-1:0] q_a,
  input  logic          re_b,
  input  logic [AW-1:0] addr_b,
  output logic [DW-1:0] q_b
);
  logic [DW-1:0] mem [2**AW];
  // byte-lane write
  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < DW/8; i++)
        if (wbe[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
  end
  // registered reads that hold between enables
  always_ff @(posedge clk) begin
    if (re_a) q_a <= mem[addr_a];
    if (re_b) q_b <= mem[addr_b];
  end
endmodule

// File: rtl/avalon_slave_mem.sv
// avalon_slave_mem: Avalon-MM responder memory with stalls, host port and counters
module avalon_slave_mem
  import avalon_slave_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                slave_read,
  input  logic                slave_write,
  input  logic [ADDR_W-1:0]   slave_address,
  input  logic [DATA_W-1:0]   slave_writedata,
  input  logic [DATA_W/8-1:0] slave_byteen,
  output logic [DATA_W-1:0]   slave_readdata,
  output logic                slave_readdatavalid,
  output logic                slave_waitrequest,
  input  logic                host_sel,
  input  logic                host_we,
  input  logic [ADDR_W-3:0]   host_addr,
  input  logic [DATA_W-1:0]   host_wdata,
  output logic [DATA_W-1:0]   host_rdata,
  output logic                host_ack,
  input  logic                cnt_clear,
  output logic [CNT_W-1:0]    rd_count,
  output logic [CNT_W-1:0]    wr_count,
  output logic                err
);
  localparam logic [3:0] WS = 4'(WAIT_STATES > MAX_WAIT ? MAX_WAIT : WAIT_STATES);
  logic [3:0] wcnt;
  logic req, rw_both, misalign, acc, rd_acc, wr_acc, host_go, rd_zero, host_zero;
  logic [DATA_W-1:0] q_a, q_b;
  err_t cause;
  host_state_t state;
  assign req = slave_read | slave_write;
  assign rw_both = slave_read & slave_write;
  assign misalign = slave_address[1:0] != 2'b00;
  // a simultaneous read+write is accepted at once so the master never deadlocks
  assign slave_waitrequest = req & ~rw_both & (wcnt != WS);
  assign acc = rst_n & req & ~slave_waitrequest;
  assign rd_acc = acc & slave_read & ~rw_both;
  assign wr_acc = acc & slave_write & ~rw_both;
  assign cause = !acc ? ERR_NONE : rw_both ? ERR_RW_BOTH : misalign ? ERR_MISALIGN : ERR_NONE;
  // host only gets the RAM in cycles without an Avalon accept
  assign host_go = rst_n & host_sel & (state == HOST_IDLE) & ~acc;
  assign slave_readdata = rd_zero ? '0 : q_a;
  assign host_rdata = host_zero ? '0 : q_b;
  avalon_slave_ram #(.AW(ADDR_W-2), .DW(DATA_W)) u_ram (
    .clk    (clk),
    .we     ((wr_acc & ~misalign) | (host_go & host_we)),
    .waddr  (wr_acc ? slave_address[ADDR_W-1:2] : host_addr),
    .wdata  (wr_acc ? slave_writedata : host_wdata),
    .wbe    (wr_acc ? slave_byteen : '1),
    .re_a   (rd_acc),
    .addr_a (slave_address[ADDR_W-1:2]),
    .q_a    (q_a),
    .re_b   (host_go & ~host_we),
    .addr_b (host_addr),
    .q_b    (q_b)
  );
  // stall counter runs while stalled, clears on accept or idle
  always_ff @(posedge clk) begin
    if (!rst_n) wcnt <= '0;
    else wcnt <= slave_waitrequest ? wcnt + 4'd1 : '0;
  end
  // read-valid pulse and zero masks for reset and misaligned reads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slave_readdatavalid <= 1'b0;
      rd_zero <= 1'b1;
      host_zero <= 1'b1;
    end else begin
      slave_readdatavalid <= rd_acc;
      if (rd_acc) rd_zero <= misalign;
      if (host_go & ~host_we) host_zero <= 1'b0;
    end
  end
  // host arbitration FSM with registered ack
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= HOST_IDLE;
      host_ack <= 1'b0;
    end else begin
      state <= host_go ? HOST_ACK : HOST_IDLE;
      host_ack <= host_go;
    end
  end
  // saturating counters and sticky error; clear beats a same-cycle accept
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clear) begin
      rd_count <= '0;
      wr_count <= '0;
      err <= 1'b0;
    end else begin
      if (rd_acc && !(&rd_count)) rd_count <= rd_count + 1'b1;
      if (wr_acc && !(&wr_count)) wr_count <= wr_count + 1'b1;
      if (cause != ERR_NONE) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_avalon_slave_mem.sv
// tb_avalon_slave_mem: directed checks of avalon_slave_mem at 0, 3 and 2 wait states
module tb_avalon_slave_mem;
  logic clk = 1'b0, rst_n, b_rst_n;
  logic a_read, a_write, a_rdv, a_wait, a_err, host_sel, host_we, host_ack, cnt_clear;
  logic [9:0] a_addr;
  logic [7:0] host_addr;
  logic [31:0] a_wdata, a_rdata, host_wdata, host_rdata;
  logic [3:0] a_be;
  logic [15:0] a_rdc, a_wrc;
  logic b_read, b_write;
  logic [9:0] b_addr;
  logic [31:0] b_wdata;
  logic [3:0] b_be;
  logic [31:0] b_rdata [2], b_hrdata [2];
  logic b_rdv [2], b_wait [2], b_hack [2], b_err [2];
  logic [15:0] b_rdc [2], b_wrc [2];
  int total = 0, passed = 0;
  logic ack_seen;
  always #5 clk = ~clk;
  avalon_slave_mem #(.ADDR_W(10), .DATA_W(32), .WAIT_STATES(0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .slave_read(a_read), .slave_write(a_write),
    .slave_address(a_addr), .slave_writedata(a_wdata), .slave_byteen(a_be),
    .slave_readdata(a_rdata), .slave_readdatavalid(a_rdv), .slave_waitrequest(a_wait),
    .host_sel(host_sel), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack), .cnt_clear(cnt_clear),
    .rd_count(a_rdc), .wr_count(a_wrc), .err(a_err)
  );
  for (genvar g = 0; g < 2; g++) begin : g_b
    avalon_slave_mem #(.ADDR_W(10), .DATA_W(32), .WAIT_STATES(g == 0 ? 3 : 2), .CNT_W(16)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .slave_read(b_read), .slave_write(b_write),
      .slave_address(b_addr), .slave_writedata(b_wdata), .slave_byteen(b_be),
      .slave_readdata(b_rdata[g]), .slave_readdatavalid(b_rdv[g]), .slave_waitrequest(b_wait[g]),
      .host_sel(1'b0), .host_we(1'b0), .host_addr(8'd0), .host_wdata(32'd0),
      .host_rdata(b_hrdata[g]), .host_ack(b_hack[g]), .cnt_clear(1'b0),
      .rd_count(b_rdc[g]), .wr_count(b_wrc[g]), .err(b_err[g])
    );
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask
  task automatic a_acc(input logic r, input logic w, input logic [9:0] ad, input logic [31:0] d, input logic [3:0] be);
    a_read = r;
    a_write = w;
    a_addr = ad;
    a_wdata = d;
    a_be = be;
    tick();
    a_read = 1'b0;
    a_write = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 0; b_rst_n = 0;
    a_read = 0; a_write = 0; a_addr = 0; a_wdata = 0; a_be = 0;
    host_sel = 0; host_we = 0; host_addr = 0; host_wdata = 0; cnt_clear = 0;
    b_read = 0; b_write = 0; b_addr = 0; b_wdata = 0; b_be = 0;
    tick(); tick();
    chk("rst_rdata", a_rdata, 32'h0);
    chk("rst_rdv", 32'(a_rdv), 32'h0);
    chk("rst_ack", 32'(host_ack), 32'h0);
    chk("rst_hrdata", host_rdata, 32'h0);
    chk("rst_cnt", {a_rdc, a_wrc}, 32'h0);
    chk("rst_err", 32'(a_err), 32'h0);
    rst_n = 1; b_rst_n = 1;
    a_write = 1; a_addr = 10'h010; a_wdata = 32'h12345678; a_be = 4'hF;
    #1 chk("ws0_wr_wait", 32'(a_wait), 32'h0);
    tick();
    a_write = 0; a_read = 1;
    #1 chk("ws0_rd_wait", 32'(a_wait), 32'h0);
    tick();
    a_read = 0;
    chk("ws0_rdv", 32'(a_rdv), 32'h1);
    chk("ws0_rdata", a_rdata, 32'h12345678);
    chk("ws0_cnt", {a_rdc, a_wrc}, {16'd1, 16'd1});
    tick();
    chk("ws0_rdv_pulse", 32'(a_rdv), 32'h0);
    chk("ws0_rdata_hold", a_rdata, 32'h12345678);
    a_acc(0, 1, 10'h020, 32'hAABBCCDD, 4'hF);
    a_acc(0, 1, 10'h020, 32'h11223344, 4'b0101);
    a_acc(1, 0, 10'h020, 32'h0, 4'h0);
    chk("be_rdata", a_rdata, 32'hAA22CC44);
    a_acc(0, 1, 10'h004, 32'hDEADBEEF, 4'hF);
    a_read = 1; a_write = 1; a_addr = 10'h004; a_wdata = 32'h0; a_be = 4'hF;
    #1 chk("rwb_wait", 32'(a_wait), 32'h0);
    tick();
    a_read = 0; a_write = 0;
    chk("rwb_rdv", 32'(a_rdv), 32'h0);
    chk("rwb_err", 32'(a_err), 32'h1);
    chk("rwb_cnt", {a_rdc, a_wrc}, {16'd2, 16'd4});
    a_acc(1, 0, 10'h004, 32'h0, 4'h0);
    chk("rwb_mem", a_rdata, 32'hDEADBEEF);
    cnt_clear = 1;
    tick();
    cnt_clear = 0;
    chk("clr_err", 32'(a_err), 32'h0);
    chk("clr_cnt", {a_rdc, a_wrc}, 32'h0);
    a_acc(1, 0, 10'h011, 32'h0, 4'h0);
    chk("mis_rdv", 32'(a_rdv), 32'h1);
    chk("mis_rdata", a_rdata, 32'h0);
    chk("mis_err", 32'(a_err), 32'h1);
    a_acc(0, 1, 10'h012, 32'hFFFFFFFF, 4'hF);
    a_acc(1, 0, 10'h010, 32'h0, 4'h0);
    chk("mis_wr_drop", a_rdata, 32'h12345678);
    chk("mis_cnt", {a_rdc, a_wrc}, {16'd2, 16'd1});
    a_read = 1; a_addr = 10'h010; cnt_clear = 1;
    tick();
    a_read = 0; cnt_clear = 0;
    chk("cw_cnt", {a_rdc, a_wrc}, 32'h0);
    chk("cw_err", 32'(a_err), 32'h0);
    chk("cw_rdv", 32'(a_rdv), 32'h1);
    a_read = 1; a_addr = 10'h000;
    host_sel = 1; host_we = 1; host_addr = 8'd5; host_wdata = 32'hCAFEF00D;
    ack_seen = 0;
    for (int i = 0; i < 128; i++) begin
      tick();
      ack_seen = ack_seen | host_ack;
    end
    a_read = 0;
    chk("hs_defer", 32'(ack_seen), 32'h0);
    chk("hs_rdc", 32'(a_rdc), 32'd128);
    tick();
    chk("hs_ack", 32'(host_ack), 32'h1);
    host_sel = 0;
    tick();
    chk("hs_ack_pulse", 32'(host_ack), 32'h0);
    a_acc(1, 0, 10'h014, 32'h0, 4'h0);
    chk("hs_mem", a_rdata, 32'hCAFEF00D);
    host_sel = 1; host_we = 0; host_addr = 8'd4;
    tick();
    chk("hr_ack", 32'(host_ack), 32'h1);
    chk("hr_data", host_rdata, 32'h12345678);
    host_sel = 0;
    tick();
    b_write = 1; b_addr = 10'h200; b_wdata = 32'h55AA55AA; b_be = 4'hF;
    repeat (4) tick();
    b_write = 0; b_read = 1;
    #1 chk("ws3_wait1", 32'(b_wait[0]), 32'h1);
    tick();
    chk("ws3_wait2", 32'(b_wait[0]), 32'h1);
    tick();
    chk("ws3_wait3", 32'(b_wait[0]), 32'h1);
    tick();
    chk("ws3_wait4", 32'(b_wait[0]), 32'h0);
    chk("ws3_early_rdv", 32'(b_rdv[0]), 32'h0);
    tick();
    b_read = 0;
    chk("ws3_rdv", 32'(b_rdv[0]), 32'h1);
    chk("ws3_rdata", b_rdata[0], 32'h55AA55AA);
    chk("ws3_cnt", {b_rdc[0], b_wrc[0]}, {16'd1, 16'd1});
    tick();
    chk("ws3_rdv_pulse", 32'(b_rdv[0]), 32'h0);
    b_write = 1; b_addr = 10'h300; b_wdata = 32'h11111111;
    repeat (4) tick();
    b_write = 0;
    tick();
    b_write = 1; b_wdata = 32'h0BADF00D;
    tick(); tick();
    chk("rs_wait", 32'(b_wait[1]), 32'h0);
    b_rst_n = 0;
    tick();
    b_write = 0; b_rst_n = 1;
    chk("rs_rdv", 32'(b_rdv[1]), 32'h0);
    chk("rs_cnt", {b_rdc[1], b_wrc[1]}, 32'h0);
    chk("rs_err", 32'(b_err[1]), 32'h0);
    b_read = 1;
    repeat (3) tick();
    b_read = 0;
    chk("rs_rdv2", 32'(b_rdv[1]), 32'h1);
    chk("rs_mem", b_rdata[1], 32'h11111111);
    b_read = 1;
    tick(); tick();
    b_rst_n = 0;
    tick();
    b_rst_n = 1; b_read = 0;
    chk("rm_rdv", 32'(b_rdv[1]), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
